glyph_renderer: RTL and testbench

GLYPH_RENDERER -- requirements
Module: glyph_renderer

---
 rtl/glyph_renderer.sv | 81 ++++++++
 tb/tb_glyph_renderer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/glyph_renderer.sv
// glyph_renderer: two-stage text-mode pixel pipeline with glyph RAM, blink, inverse and underline cursor
module glyph_renderer #(
  parameter int CHAR_W    = 8,
  parameter int CHAR_H    = 16,
  parameter int NUM_CHARS = 128,
  parameter int COLOR_W   = 4,
  parameter int BLINK_DIV = 30,
  parameter     INIT_FILE = ""
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic [$clog2(NUM_CHARS)-1:0]         char_code,
  input  logic [$clog2(CHAR_W)-1:0]            dot_x,
  input  logic [$clog2(CHAR_H)-1:0]            scan_y,
  input  logic [COLOR_W-1:0]                   fg,
  input  logic [COLOR_W-1:0]                   bg,
  input  logic                                 attr_inv,
  input  logic                                 attr_blink,
  input  logic                                 cursor_here,
  input  logic                                 blank,
  input  logic                                 frame_start,
  input  logic                                 rom_we,
  input  logic [$clog2(NUM_CHARS*CHAR_H)-1:0]  rom_addr,
  input  logic [CHAR_W-1:0]                    rom_wdata,
  output logic [COLOR_W-1:0]                   pixel_color,
  output logic                                 pixel_on,
  output logic                                 pixel_valid
);
  localparam int XW = $clog2(CHAR_W);
  localparam int YW = $clog2(CHAR_H);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [CHAR_W-1:0] mem [NUM_CHARS*CHAR_H];
  logic [CHAR_W-1:0] row_s1;
  logic [XW-1:0] x_s1;
  logic [YW-1:0] y_s1;
  logic [COLOR_W-1:0] fg_s1, bg_s1;
  logic inv_s1, blink_s1, cur_s1, blank_s1, valid_s1;
  logic [BW-1:0] blink_cnt;
  logic blink_phase;
  logic g;
  always_ff @(posedge clk) begin
    if (rst_n && rom_we) mem[rom_addr] <= rom_wdata;
    row_s1 <= mem[{char_code, scan_y}];
  end
  always_ff @(posedge clk) begin
    x_s1     <= dot_x;
    y_s1     <= scan_y;
    fg_s1    <= fg;
    bg_s1    <= bg;
    inv_s1   <= attr_inv;
    blink_s1 <= attr_blink;
    cur_s1   <= cursor_here;
    blank_s1 <= blank;
    valid_s1 <= rst_n & en;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      blink_cnt   <= blink_cnt == BW'(BLINK_DIV - 1) ? '0 : blink_cnt + BW'(1);
      blink_phase <= blink_cnt == BW'(BLINK_DIV - 1) ? ~blink_phase : blink_phase;
    end
  end
  always_comb begin
    g = row_s1[~x_s1] & ~(blink_s1 & ~blink_phase);
    g = g ^ inv_s1 ^ (cur_s1 & blink_phase & (y_s1 >= YW'(CHAR_H - 2)));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_color <= '0;
      pixel_on    <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_color <= blank_s1 ? '0 : (g ? fg_s1 : bg_s1);
      pixel_on    <= g & ~blank_s1;
      pixel_valid <= valid_s1;
    end
  end
endmodule

// File: tb/tb_glyph_renderer.sv
// tb_glyph_renderer: randomized and directed checks against a frame-count/array reference model
module tb_glyph_renderer;
  localparam int CW = 8, CH = 16, NC = 128, COLW = 4, BD = 2;
  logic clk = 1'b0;
  logic rst_n, en, attr_inv, attr_blink, cursor_here, blank, frame_start, rom_we;
  logic [6:0] char_code;
  logic [2:0] dot_x;
  logic [3:0] scan_y;
  logic [COLW-1:0] fg, bg, pixel_color;
  logic [10:0] rom_addr;
  logic [7:0] rom_wdata;
  logic pixel_on, pixel_valid;
  logic [7:0] mm [2048];
  bit kn [2048];
  int frames = 0;
  logic [5:0] pend = '0;
  bit pend_kn = 0;
  int errs = 0, checks = 0;
  logic [3:0] k35 [8] = '{4'hF, 4'h1, 4'hF, 4'h1, 4'h1, 4'hF, 4'h1, 4'hF};
  logic [3:0] k36 [8] = '{4'h1, 4'hF, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 4'h1};
  logic [3:0] k38 [3] = '{4'h5, 4'hA, 4'hA};

  glyph_renderer #(.CHAR_W(CW), .CHAR_H(CH), .NUM_CHARS(NC), .COLOR_W(COLW), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .char_code(char_code), .dot_x(dot_x), .scan_y(scan_y),
    .fg(fg), .bg(bg), .attr_inv(attr_inv), .attr_blink(attr_blink), .cursor_here(cursor_here),
    .blank(blank), .frame_start(frame_start), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .pixel_color(pixel_color), .pixel_on(pixel_on), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [10:0] a;
    logic g;
    bit ph, known, rst_k;
    logic [5:0] e;
    if (!rst_n) frames = 0;
    else if (frame_start) frames++;
    ph = ((frames / BD) % 2) == 1;
    a = {char_code, scan_y};
    g = mm[a][7 - dot_x];
    if (attr_blink && !ph) g = 1'b0;
    if (attr_inv) g = !g;
    if (cursor_here && ph && scan_y >= CH - 2) g = !g;
    e = {en && rst_n, g && !blank, blank ? 4'h0 : (g ? fg : bg)};
    known = kn[a];
    if (rst_n && rom_we) begin
      mm[rom_addr] = rom_wdata;
      kn[rom_addr] = 1;
    end
    rst_k = rst_n;
    @(posedge clk);
    #1;
    if (!rst_k) check("reset_out", {pixel_valid, pixel_on, pixel_color}, 6'b0);
    else if (pend_kn) check("pixel", {pixel_valid, pixel_on, pixel_color}, pend);
    else check("pixel_valid", pixel_valid, pend[5]);
    pend = e;
    pend_kn = known;
  endtask

  task automatic idle();
    en = 0; frame_start = 0; rom_we = 0; attr_inv = 0; attr_blink = 0;
    cursor_here = 0; blank = 0;
  endtask

  initial begin
    rst_n = 0; idle(); char_code = 7'h40; dot_x = 0; scan_y = 0; fg = 0; bg = 0;
    rom_addr = 0; rom_wdata = 0;
    repeat (3) step();
    rst_n = 1;
    for (int i = 0; i < 128; i++) begin
      rom_we = 1; rom_addr = 11'h400 + 11'(i); rom_wdata = 8'($urandom); step();
    end
    for (int i = 0; i < 16; i++) begin
      rom_addr = 11'h470 + 11'(i); rom_wdata = 8'h00; step();
    end
    rom_addr = 11'h413; rom_wdata = 8'hA5; step();
    rom_we = 0;
    char_code = 7'h41; scan_y = 4'd3; fg = 4'hF; bg = 4'h1;
    for (int i = 0; i < 9; i++) begin
      en = i < 8; dot_x = 3'(i); step();
      if (i >= 1) check("plain", pixel_color, k35[i-1]);
    end
    attr_inv = 1;
    for (int i = 0; i < 9; i++) begin
      en = i < 8; dot_x = 3'(i); step();
      if (i >= 1) check("inverse", pixel_color, k36[i-1]);
    end
    attr_inv = 0; blank = 1;
    for (int i = 0; i < 3; i++) begin
      en = i < 2; dot_x = 3'(i); step();
      if (i >= 1) check("blank", {pixel_on, pixel_color}, 5'h0);
    end
    idle(); rst_n = 0; step(); rst_n = 1;
    dot_x = 0; attr_blink = 1;
    for (int f = 0; f < 6; f++) begin
      if (f > 0) begin
        frame_start = 1; en = 0; step(); frame_start = 0;
      end
      en = 1; step(); en = 0; step();
      check("blink", pixel_on, 32'((f / 2) % 2));
    end
    attr_blink = 0; frame_start = 1; step(); frame_start = 0;
    check("phase_on", dut.blink_phase, 1);
    cursor_here = 1; char_code = 7'h47; fg = 4'hA; bg = 4'h5;
    for (int i = 0; i < 4; i++) begin
      en = i < 3; scan_y = 4'(13 + i); dot_x = 3'($urandom); step();
      if (i >= 1) check("cursor", pixel_color, k38[i-1]);
    end
    cursor_here = 0;
    rom_we = 1; rom_addr = 11'h425; rom_wdata = 8'h00; en = 0; step();
    rom_wdata = 8'h80; en = 1; char_code = 7'h42; scan_y = 4'd5; dot_x = 0; step();
    rom_we = 0; step();
    check("rbw_old", pixel_on, 0);
    en = 0; step();
    check("rbw_new", pixel_on, 1);
    en = 1; step(); step();
    rst_n = 0; en = 0; step();
    rst_n = 1; step();
    check("flush_v1", pixel_valid, 0);
    step();
    check("flush_v2", pixel_valid, 0);
    check("phase_rst", dut.blink_phase, 0);
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom % 64) != 0;
      en = 1'($urandom); frame_start = ($urandom % 6) == 0;
      char_code = 7'h40 + 7'($urandom % 8); dot_x = 3'($urandom); scan_y = 4'($urandom);
      fg = 4'($urandom); bg = 4'($urandom);
      attr_inv = 1'($urandom); attr_blink = 1'($urandom); cursor_here = 1'($urandom);
      blank = ($urandom % 8) == 0;
      rom_we = ($urandom % 4) == 0; rom_addr = 11'h400 + 11'($urandom % 128);
      rom_wdata = 8'($urandom);
      step();
    end
    rst_n = 1; idle();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
